lcd_line_buffer: RTL

Dual-bank RGB888 line buffer between a pixel source (pattern/pixel generator or future frame source) and the LCD timing/output stage of the 480x272 Tang Nano 9k panel path. The producer pushes pixels in raster order over a valid/ready handshake. The display side pulls one full line per active-DE period. The block decouples the producer's rate from the panel's pixel clock and reports underflow when a line is not ready in time.

---
 rtl/lcd_line_buffer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_line_buffer.sv
// Dual-bank RGB888 line buffer: a raster-order producer fills one bank while the
// LCD timing side streams the other out, one full line per DE period.
module lcd_line_buffer #(
    parameter int H_ACTIVE = 480,
    parameter int XW       = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        wr_sof,
    input  logic [23:0] wr_data,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        underflow
);

    localparam int             AW     = XW + 1;
    localparam logic [XW-1:0]  LAST_X = XW'(H_ACTIVE - 1);
    localparam logic [XW:0]    H_END  = (XW + 1)'(H_ACTIVE);

    typedef enum logic {
        WAIT_SOF,
        FILL
    } wr_state_t;

    // Bank select is the address MSB, so each bank occupies its own half.
    logic [23:0] mem [0:(2**AW)-1];

    wr_state_t     wr_state_reg, wr_state_next;
    logic [XW-1:0] wr_x_reg, wr_x_next;
    logic          wr_bank_reg, wr_bank_next;
    logic          wr_en;
    logic [XW-1:0] wr_addr_x;
    logic          fill_done;

    logic [1:0]    bank_full_reg, bank_full_next;
    logic [1:0]    bank_set, bank_clr;

    logic          de_prev_reg;
    logic [XW:0]   rd_x_reg;
    logic          rd_bank_reg;
    logic          line_valid_reg;
    logic          underflow_reg;
    logic [23:0]   rgb_reg;
    logic          de_reg, hsync_reg, vsync_reg;

    logic          line_start, line_end, line_ok, pix_ok;

    // ---------------------------------------------------------------- write side
    always_comb begin
        wr_state_next = wr_state_reg;
        wr_x_next     = wr_x_reg;
        wr_bank_next  = wr_bank_reg;
        wr_ready      = 1'b1;
        wr_en         = 1'b0;
        wr_addr_x     = '0;
        fill_done     = 1'b0;
        case (wr_state_reg)
            WAIT_SOF: begin
                if (wr_valid && wr_sof) begin
                    wr_en         = 1'b1;
                    wr_x_next     = XW'(1);
                    wr_state_next = FILL;
                end
            end
            FILL: begin
                wr_ready = !bank_full_reg[wr_bank_reg];
                if (wr_valid && !bank_full_reg[wr_bank_reg]) begin
                    wr_en = 1'b1;
                    if (wr_sof) begin
                        // Restart the current bank; a partial line is abandoned.
                        wr_x_next = XW'(1);
                    end else begin
                        wr_addr_x = wr_x_reg;
                        if (wr_x_reg == LAST_X) begin
                            fill_done    = 1'b1;
                            wr_bank_next = ~wr_bank_reg;
                            wr_x_next    = '0;
                        end else begin
                            wr_x_next = wr_x_reg + XW'(1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_reg <= WAIT_SOF;
            wr_x_reg     <= '0;
            wr_bank_reg  <= 1'b0;
        end else begin
            wr_state_reg <= wr_state_next;
            wr_x_reg     <= wr_x_next;
            wr_bank_reg  <= wr_bank_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_reg, wr_addr_x}] <= wr_data;
        end
    end

    // ---------------------------------------------------------------- bank flags
    // Set and clear never target the same bank in one cycle, so per-bank
    // set-over-hold logic lets both sides update independently.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_set[gi]       = fill_done && (wr_bank_reg == 1'(gi));
            assign bank_clr[gi]       = line_end && line_valid_reg && (rd_bank_reg == 1'(gi));
            assign bank_full_next[gi] = bank_set[gi] | (bank_full_reg[gi] & ~bank_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full_reg <= 2'b00;
        end else begin
            bank_full_reg <= bank_full_next;
        end
    end

    // ---------------------------------------------------------------- read side
    assign line_start = de_in && !de_prev_reg;
    assign line_end   = !de_in && de_prev_reg;
    // On the first DE cycle the validity decision is not yet registered.
    assign line_ok    = line_start ? bank_full_reg[rd_bank_reg] : line_valid_reg;
    assign pix_ok     = de_in && line_ok && (rd_x_reg < H_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            de_prev_reg    <= 1'b0;
            rd_x_reg       <= '0;
            rd_bank_reg    <= 1'b0;
            line_valid_reg <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            de_prev_reg <= de_in;
            if (line_start) begin
                line_valid_reg <= bank_full_reg[rd_bank_reg];
                if (!bank_full_reg[rd_bank_reg]) begin
                    underflow_reg <= 1'b1;
                end
            end
            if (de_in) begin
                if (rd_x_reg != H_END) begin
                    rd_x_reg <= rd_x_reg + (XW + 1)'(1);
                end
            end else begin
                rd_x_reg <= '0;
            end
            if (line_end && line_valid_reg) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
        end
    end

    // Registered RAM read doubles as the pixel output register (black when idle).
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_reg <= '0;
        end else if (pix_ok) begin
            rgb_reg <= mem[{rd_bank_reg, rd_x_reg[XW-1:0]}];
        end else begin
            rgb_reg <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_reg    <= 1'b0;
            hsync_reg <= 1'b0;
            vsync_reg <= 1'b0;
        end else begin
            de_reg    <= de_in;
            hsync_reg <= hsync_in;
            vsync_reg <= vsync_in;
        end
    end

    assign red       = rgb_reg[23:16];
    assign green     = rgb_reg[15:8];
    assign blue      = rgb_reg[7:0];
    assign de_out    = de_reg;
    assign hsync_out = hsync_reg;
    assign vsync_out = vsync_reg;
    assign underflow = underflow_reg;

endmodule
